// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_pkg
// Brief    : Shared types and constants for the sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_addsub.sv
`default_nettype none
// ============================================================================
// Module   : div_addsub
// Brief    : (WIDTH+1)-bit adder/subtractor shared by the iteration and fix-up.
// Revision : 1.0 - initial release
// ============================================================================
module div_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Multi-cycle signed non-restoring divider (quotient LO, remainder HI).
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Clow,
  output logic [WIDTH-1:0] Chigh,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_zero;
  logic [WIDTH-1:0] r_clow;
  logic [WIDTH-1:0] r_chigh;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_op_a;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_rem;

  // Magnitudes fit in WIDTH unsigned bits, including 2^(WIDTH-1).
  assign w_abs_a = A[WIDTH-1] ? -A : A;
  assign w_abs_b = B[WIDTH-1] ? -B : B;

  // RUN feeds the shifted remainder; FIX re-uses the unit for the final add.
  assign w_op_a = (r_state == S_RUN) ? {r_p[WIDTH-1:0], r_q[WIDTH-1]} : r_p;
  assign w_sub  = (r_state == S_RUN) && !r_p[WIDTH];
  assign w_rem  = r_p[WIDTH] ? w_sum[WIDTH-1:0] : r_p[WIDTH-1:0];

  div_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (w_op_a),
    .b   ({1'b0, r_d}),
    .sub (w_sub),
    .sum (w_sum)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_p      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_zero   <= 1'b0;
      r_clow   <= '0;
      r_chigh  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_sign_r <= A[WIDTH-1];
            r_zero   <= (B == '0);
            // A zero divisor parks the raw dividend in Q for the HI result.
            r_q      <= (B == '0) ? A : w_abs_a;
            r_d      <= w_abs_b;
            r_p      <= '0;
            r_count  <= c_last;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_zero) begin
            r_clow  <= '1;
            r_chigh <= r_q;
            r_dbz   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_p <= w_sum;
            r_q <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
            if (r_count == '0) begin
              r_state <= S_FIX;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        S_FIX: begin
          r_clow  <= r_sign_q ? -r_q : r_q;
          r_chigh <= r_sign_r ? -w_rem : w_rem;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Clow        = r_clow;
  assign Chigh       = r_chigh;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
